// File: rtl/hp_reg3_sync.sv
// hp_reg3_sync: host-to-parasite register 3 data FIFO (two byte slots).
// The host writes, the parasite reads. In one-byte mode slot 0 acts as a
// single latch. In two-byte mode the status flags only change on complete
// pair boundaries, because they follow the slot-1 flag.
// Optional feature macro: HP_REG3_OVERRUN_DETECT_EN adds the sticky
// h_overrun / p_underrun error flags. Without it both flags are tied low.
module hp_reg3_sync #(
  parameter logic [7:0] BYTE0_RST = 8'hAA,
  parameter logic [7:0] BYTE1_RST = 8'hEE
) (
  input  logic       h_phi2,
  input  logic       h_rst_b,
  input  logic       h_we,
  input  logic [7:0] h_data,
  input  logic       p_re,
  input  logic       one_byte_mode,
  input  logic       overrun_clr,
  output logic [7:0] p_data,
  output logic       p_data_available,
  output logic       h_full,
  output logic       h_overrun,
  output logic       p_underrun
);

  // Slot-occupied flags and slot data registers.
  logic       f0;
  logic       f1;
  logic [7:0] byte0;
  logic [7:0] byte1;

  // Next-state values and load enables for the data registers.
  logic       f0_nxt;
  logic       f1_nxt;
  logic       load0;
  logic       load1;

  // Qualified accesses, evaluated against the state before the edge.
  logic       wr_ok;
  logic       rd_ok;
  logic       wr_ignored;
  logic       rd_ignored;

  // Both status flags look at the same slot: slot 0 in latch mode, and the
  // pair-completion slot in two-byte mode.
  always_comb begin
    h_full           = one_byte_mode ? f0 : f1;
    p_data_available = one_byte_mode ? f0 : f1;
    p_data           = f0 ? byte0 : byte1;
  end

  // A write is legal only when not full, and a read only when data is
  // available. These two conditions are mutually exclusive.
  always_comb begin
    wr_ok      = h_we & ~h_full;
    rd_ok      = p_re & p_data_available;
    wr_ignored = h_we & h_full;
    rd_ignored = p_re & ~p_data_available;
  end

  // Slot sequencing. Writes fill slot 0, then slot 1. Reads drain slot 0,
  // then slot 1. Latch mode keeps slot 1 flushed.
  always_comb begin
    f0_nxt = f0;
    f1_nxt = f1;
    load0  = 1'b0;
    load1  = 1'b0;

    if (wr_ok) begin
      if (!f0) begin
        load0  = 1'b1;
        f0_nxt = 1'b1;
      end else if (!one_byte_mode) begin
        load1  = 1'b1;
        f1_nxt = 1'b1;
      end
    end

    if (rd_ok) begin
      if (one_byte_mode || f0) begin
        f0_nxt = 1'b0;
      end else begin
        f1_nxt = 1'b0;
      end
    end

    if (one_byte_mode) begin
      f1_nxt = 1'b0;
    end
  end

  // Flag register. Reset discards any partially filled pair.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      f0 <= 1'b0;
      f1 <= 1'b0;
    end else begin
      f0 <= f0_nxt;
      f1 <= f1_nxt;
    end
  end

  // Data registers. They load only on an accepted write to their slot.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      byte0 <= BYTE0_RST;
      byte1 <= BYTE1_RST;
    end else begin
      if (load0) begin
        byte0 <= h_data;
      end
      if (load1) begin
        byte1 <= h_data;
      end
    end
  end

`ifdef HP_REG3_OVERRUN_DETECT_EN
  logic overrun_q;
  logic underrun_q;

  // Sticky error flags. A set in the same cycle as a clear takes priority.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (wr_ignored) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
      if (rd_ignored) begin
        underrun_q <= 1'b1;
      end else if (overrun_clr) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign h_overrun  = overrun_q;
  assign p_underrun = underrun_q;
`else
  logic unused_err;

  assign unused_err = overrun_clr ^ wr_ignored ^ rd_ignored;
  assign h_overrun  = 1'b0;
  assign p_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_hp_reg3_sync.sv
// Directed testbench for hp_reg3_sync. It covers both builds: the expected
// error-flag values follow HP_REG3_OVERRUN_DETECT_EN.
module tb_hp_reg3_sync;

  logic       h_phi2;
  logic       h_rst_b;
  logic       h_we;
  logic [7:0] h_data;
  logic       p_re;
  logic       one_byte_mode;
  logic       overrun_clr;
  logic [7:0] p_data;
  logic       p_data_available;
  logic       h_full;
  logic       h_overrun;
  logic       p_underrun;

  int compare_count = 0;
  int fail_count    = 0;

`ifdef HP_REG3_OVERRUN_DETECT_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  hp_reg3_sync dut (
    .h_phi2           (h_phi2),
    .h_rst_b          (h_rst_b),
    .h_we             (h_we),
    .h_data           (h_data),
    .p_re             (p_re),
    .one_byte_mode    (one_byte_mode),
    .overrun_clr      (overrun_clr),
    .p_data           (p_data),
    .p_data_available (p_data_available),
    .h_full           (h_full),
    .h_overrun        (h_overrun),
    .p_underrun       (p_underrun)
  );

  // 10-time-unit clock with rising edges at 5, 15, 25, ...
  initial begin
    h_phi2 = 1'b0;
    forever #5 h_phi2 = ~h_phi2;
  end

  // Drive one cycle of strobes from a falling edge, then release them 1
  // unit after the rising edge, so that outputs can be sampled there.
  task automatic applyStimulus(input logic we, input logic [7:0] data,
                               input logic re, input logic clr);
    @(negedge h_phi2);
    h_we        = we;
    h_data      = data;
    p_re        = re;
    overrun_clr = clr;
    @(posedge h_phi2);
    #1;
    h_we        = 1'b0;
    p_re        = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compare_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] exp_data,
                          input logic exp_avail, input logic exp_full,
                          input logic exp_ovr, input logic exp_und);
    checkOutput({tag, ".p_data"}, p_data, exp_data);
    checkOutput({tag, ".avail"}, {7'd0, p_data_available}, {7'd0, exp_avail});
    checkOutput({tag, ".full"}, {7'd0, h_full}, {7'd0, exp_full});
    checkOutput({tag, ".overrun"}, {7'd0, h_overrun}, {7'd0, exp_ovr});
    checkOutput({tag, ".underrun"}, {7'd0, p_underrun}, {7'd0, exp_und});
  endtask

  initial begin
    h_rst_b       = 1'b0;
    h_we          = 1'b0;
    h_data        = 8'h00;
    p_re          = 1'b0;
    one_byte_mode = 1'b1;
    overrun_clr   = 1'b0;
    #12;
    checkAll("in_reset", 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge h_phi2);
    h_rst_b = 1'b1;
    @(posedge h_phi2);
    #1;
    checkAll("after_reset", 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);

    // One-byte latch mode
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    checkAll("ob_wr5A", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("ob_rd5A", 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkAll("ob_wr11", 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    checkAll("ob_wr22_full", 8'h11, 1'b1, 1'b1, ERR_ON, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("ob_rd11", 8'hEE, 1'b0, 1'b0, ERR_ON, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("ob_clr", 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two-byte pair
    one_byte_mode = 1'b0;
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    checkAll("tb_wr12", 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
    checkAll("tb_wr34", 8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("tb_rd1", 8'h34, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("tb_rd2", 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);

    // Early write after one byte has drained. Clear is applied in the same
    // cycle as the ignored write: the set must take priority.
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("ew_rd1", 8'h34, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkAll("ew_wr99", 8'h34, 1'b1, 1'b1, ERR_ON, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("ew_rd2", 8'h34, 1'b0, 1'b0, ERR_ON, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("ew_clr", 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);

    // Underrun, then a collision on the empty FIFO
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("un_rd", 8'h34, 1'b0, 1'b0, 1'b0, ERR_ON);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("un_clr", 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkAll("col", 8'h77, 1'b0, 1'b0, 1'b0, ERR_ON);

    // Asynchronous reset mid-pair, asserted between edges
    #2;
    h_rst_b = 1'b0;
    #1;
    checkAll("mid_rst", 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge h_phi2);
    h_rst_b = 1'b1;
    applyStimulus(1'b1, 8'hAB, 1'b0, 1'b0);
    checkAll("post_rst_wr", 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCD, 1'b0, 1'b0);
    checkAll("post_rst_pair", 8'hAB, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule

// File: doc/hp_reg3_sync.md
Name: hp_reg3_sync

Overview:
Register 3 data FIFO for the host-to-parasite direction. It is the write-side counterpart of the parasite-to-host register 3 path. It is a 2-byte FIFO: the host writes, the parasite reads. In one-byte mode it behaves as a single latch. In two-byte mode it supports 16-bit block transfers, and its status flags change only on complete two-byte boundaries. All logic runs on a single clock, with host and parasite accesses presented as one-cycle qualified strobes.

Parameters:
BYTE0_RST, 8'hAA, reset value of slot-0 data register
BYTE1_RST, 8'hEE, reset value of slot-1 data register

Ports:
h_phi2  input  1  clock; all state updates on rising edge
h_rst_b  input  1  asynchronous active-low reset
h_we  input  1  host write strobe, already qualified by register-3 data select; one cycle per access
h_data  input  8  host write data, sampled when h_we=1
p_re  input  1  parasite read strobe, already qualified by register-3 data select; one cycle per access
one_byte_mode  input  1  1 = one-byte (latch) mode, 0 = two-byte mode
overrun_clr  input  1  clears sticky error flags (used only with the optional feature)
p_data  output  8  parasite read data
p_data_available  output  1  parasite-side data-available / PNMI source
h_full  output  1  host-side full flag (host sees "not full" as !h_full)
h_overrun  output  1  sticky: host wrote while full
p_underrun  output  1  sticky: parasite read while nothing available

Behaviour:
State:
- f0, f1: slot-occupied flags.
- byte0, byte1: 8-bit data registers.

Reset (async, h_rst_b=0):
- f0=f1=0; byte0=BYTE0_RST; byte1=BYTE1_RST.
- Outputs during and after reset: p_data_available=0, h_full=0, p_data=BYTE1_RST (slot 0 empty), h_overrun=0, p_underrun=0.
- A reset asserted mid-transfer discards any partial pair.

Combinational outputs:
- h_full = one_byte_mode ? f0 : f1
- p_data_available = one_byte_mode ? f0 : f1
- p_data = f0 ? byte0 : byte1

Host write (h_we=1, rising edge):
- One-byte mode, f0=0: byte0<=h_data, f0<=1.
- Two-byte mode, f0=0 and f1=0: byte0<=h_data, f0<=1.
- Two-byte mode, f0=1 and f1=0: byte1<=h_data, f1<=1.
- Write while h_full=1: ignored; data and flags unchanged.
- Two-byte mode, f0=0 and f1=1 (second byte not yet drained): h_full=1, so the write is ignored.

Parasite read (p_re=1, rising edge):
- Legal only when p_data_available=1. Before the edge, p_data already presents the byte being consumed.
- One-byte mode: f0<=0.
- Two-byte mode: if f0=1 then f0<=0, else f1<=0.
- After a pair is complete, p_data_available and h_full stay 1 until both bytes are read. They deassert on the edge that consumes byte1.
- Read while p_data_available=0: ignored.

Simultaneous h_we and p_re:
- Both are evaluated independently against pre-edge state.
- A legal write needs h_full=0 and a legal read needs p_data_available=1. These are mutually exclusive, so at most one takes effect per cycle.

Latency:
- A flag change is visible one edge after the strobe.
- A write-to-read round trip takes 1 cycle.

Mode switching:
- While one_byte_mode=1, f1 is held clear each edge, flushing any stranded byte1.
- Switching 1→0 with f0=1 continues as a half-filled pair.
- Mode is assumed stable during a transfer. A mid-pair switch follows the rules above with no further guarantee.

Optional Feature:
Macro HP_REG3_OVERRUN_DETECT_EN.
- Defined:
  - h_overrun sets on any host write ignored because h_full=1.
  - p_underrun sets on any read ignored because p_data_available=0.
  - Both flags are sticky, cleared by overrun_clr=1 at an edge or by reset.
  - If set and clear occur in the same cycle, set wins.
- Undefined: h_overrun and p_underrun are tied to 0; overrun_clr is unused.
- FIFO behaviour is identical in both builds.

Test Plan:
- Reset values: reset, release -> p_data_available=0, h_full=0, p_data=8'hEE. Then one_byte_mode=1, write 8'h5A -> next cycle p_data_available=1, h_full=1, p_data=8'h5A.
- One-byte latch: write 8'h11, write 8'h22 while full -> p_data stays 8'h11; p_re -> both flags 0. With the macro: h_overrun=1 until overrun_clr.
- Two-byte pair:
  - one_byte_mode=0; write 8'h12 -> flags 0.
  - write 8'h34 -> p_data_available=1, h_full=1, p_data=8'h12.
  - p_re -> p_data=8'h34, flags still 1.
  - p_re -> flags 0.
- Two-byte early write: after a pair, read one byte, host writes 8'h99 -> ignored; second read returns 8'h34; with the macro, h_overrun=1.
- Underrun and collision:
  - p_re on an empty FIFO -> no state change (with the macro, p_underrun=1).
  - h_we and p_re together on an empty FIFO -> only the write takes effect.
- Reset mid-pair: after the first two-byte write, assert h_rst_b=0 asynchronously between edges -> flags clear immediately; byte0 returns to 8'hAA.
